// File: rtl/char_stream_normalizer.sv
// rtl/char_stream_normalizer.sv - ASCII byte normalizer (case fold, whitespace collapse, NUL drop) with FWFT output FIFO.
// Feeds the begin/end block checker one normalized byte per handshake.
module char_stream_normalizer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] collapsed_cnt
);

  typedef enum logic {S_TEXT, S_SPACE} state_t;

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_collapsed_cnt;

  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_collapse;
  logic          w_is_ws;
  logic          w_is_nul;
  logic [7:0]    w_folded;
  logic [7:0]    w_push_data;

  // Readiness depends only on registered occupancy, so discarded bytes still need a free slot.
  assign in_ready      = reset && (r_count != L_FULL);
  assign out_valid     = reset && (r_count != '0);
  assign out_data      = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign collapsed_cnt = r_collapsed_cnt;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_is_ws  = (in_data == 8'h20) || (in_data == 8'h09) ||
                    (in_data == 8'h0A) || (in_data == 8'h0D);
  assign w_is_nul = (in_data == 8'h00);
  assign w_folded = ((in_data >= 8'h41) && (in_data <= 8'h5A)) ? (in_data + 8'h20) : in_data;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = w_folded;
    w_collapse  = 1'b0;
    if (w_accept && !w_is_nul) begin
      if (w_is_ws) begin
        if (r_state == S_SPACE) begin
          w_collapse = 1'b1;
        end else begin
          w_push      = 1'b1;
          w_push_data = 8'h20;
        end
        w_state_nxt = S_SPACE;
      end else begin
        w_push      = 1'b1;
        w_state_nxt = S_TEXT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_TEXT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_collapsed_cnt <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_collapse && (r_collapsed_cnt != 8'hFF)) begin
        r_collapsed_cnt <= r_collapsed_cnt + 8'h01;
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

endmodule

// File: tb/tb_char_stream_normalizer.sv
// tb/tb_char_stream_normalizer.sv - self-checking bench for char_stream_normalizer.
module tb_char_stream_normalizer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [7:0] collapsed_cnt;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] obs[$];
  int m_coll = 0;
  bit m_sp = 1'b0;
  bit m_acc;
  bit m_pop;

  typedef struct {
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[17];

  char_stream_normalizer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .collapsed_cnt(collapsed_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_ws(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
  endfunction

  // Reference: apply the normalization rules to one accepted byte.
  function void model_byte(input logic [7:0] b);
    if (b == 8'h00) return;
    if (is_ws(b)) begin
      if (m_sp) m_coll = (m_coll >= 255) ? 255 : m_coll + 1;
      else q.push_back(8'h20);
      m_sp = 1'b1;
    end else begin
      q.push_back((b >= "A" && b <= "Z") ? b + 8'd32 : b);
      m_sp = 1'b0;
    end
  endfunction

  function void model_clear();
    q.delete();
    m_coll = 0;
    m_sp = 1'b0;
  endfunction

  always @(negedge reset) model_clear();

  always @(posedge clk) begin
    if (!reset) begin
      model_clear();
    end else begin
      m_acc = in_valid && (q.size() < 8);
      m_pop = out_ready && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_acc) model_byte(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset) begin
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_collapsed", {24'd0, collapsed_cnt}, 0);
      end else begin
        chk("in_ready", {31'd0, in_ready}, (q.size() != 8) ? 1 : 0);
        chk("out_valid", {31'd0, out_valid}, (q.size() != 0) ? 1 : 0);
        chk("out_data", {24'd0, out_data}, (q.size() != 0) ? {24'd0, q[0]} : 0);
        chk("collapsed", {24'd0, collapsed_cnt}, m_coll);
        if (out_valid && out_ready) obs.push_back(out_data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit took;
    int n;
    logic [7:0] b;

    tbl[0]  = '{8'h61, 1'b1, 8'h61};
    tbl[1]  = '{8'h20, 1'b1, 8'h20};
    tbl[2]  = '{8'h09, 1'b0, 8'h00};
    tbl[3]  = '{8'h42, 1'b1, 8'h62};
    tbl[4]  = '{8'h65, 1'b1, 8'h65};
    tbl[5]  = '{8'h4E, 1'b1, 8'h6E};
    tbl[6]  = '{8'h64, 1'b1, 8'h64};
    tbl[7]  = '{8'h00, 1'b0, 8'h00};
    tbl[8]  = '{8'h44, 1'b1, 8'h64};
    tbl[9]  = '{8'h0A, 1'b1, 8'h20};
    tbl[10] = '{8'h0D, 1'b0, 8'h00};
    tbl[11] = '{8'h00, 1'b0, 8'h00};
    tbl[12] = '{8'h80, 1'b1, 8'h80};
    tbl[13] = '{8'h5A, 1'b1, 8'h7A};
    tbl[14] = '{8'h40, 1'b1, 8'h40};
    tbl[15] = '{8'h5B, 1'b1, 8'h5B};
    tbl[16] = '{8'hFF, 1'b1, 8'hFF};

    #1 reset = 1'b0;
    #2 chk_en = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    tick();

    // Single-byte vectors, consumer always ready; FSM state carries across rows.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data = tbl[i].din;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, tbl[i].exp_data});
    end
    chk("vec_collapsed", {24'd0, collapsed_cnt}, 2);
    tick();

    // Fill to full with consumer stalled, then drain nine letters.
    out_ready = 1'b0;
    obs.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 8'h61 + 8'(i);
      took = 1'b0;
      for (n = 0; n < 20 && !took; n++) begin
        took = in_ready;
        tick();
      end
      chk($sformatf("fill%0d_accepted", i), {31'd0, took}, 1);
    end
    in_data = 8'h69;
    chk("full_in_ready", {31'd0, in_ready}, 0);
    tick();
    chk("full_hold_in_ready", {31'd0, in_ready}, 0);
    out_ready = 1'b1;
    took = 1'b0;
    for (n = 0; n < 20 && !took; n++) begin
      took = in_ready;
      tick();
    end
    chk("ninth_accepted", {31'd0, took}, 1);
    in_valid = 1'b0;
    for (n = 0; n < 30 && obs.size() < 9; n++) tick();
    chk("drain_count", obs.size(), 9);
    for (int i = 0; i < 9 && i < obs.size(); i++)
      chk($sformatf("drain%0d", i), {24'd0, obs[i]}, 32'h61 + i);
    tick();

    // Four buffered, then simultaneous push/pop across the pointer wrap.
    out_ready = 1'b0;
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 8'h70 + 8'(i);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 4; i < 7; i++) begin
      in_data = 8'h70 + 8'(i);
      tick();
      chk($sformatf("pp%0d_in_ready", i), {31'd0, in_ready}, 1);
    end
    in_valid = 1'b0;
    for (n = 0; n < 30 && obs.size() < 7; n++) tick();
    chk("wrap_count", obs.size(), 7);
    for (int i = 0; i < 7 && i < obs.size(); i++)
      chk($sformatf("wrap%0d", i), {24'd0, obs[i]}, 32'h70 + i);

    // Long whitespace run right after reset: one space out, counter saturates.
    do_reset();
    obs.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h20;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ws_out_count", obs.size(), 1);
    if (obs.size() > 0) chk("ws_out_byte", {24'd0, obs[0]}, 32'h20);
    chk("ws_sat", {24'd0, collapsed_cnt}, 255);

    // Reset between edges with five bytes buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'h41 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 0);
    chk("midrst_out_data", {24'd0, out_data}, 0);
    chk("midrst_collapsed", {24'd0, collapsed_cnt}, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 0);
    tick();
    in_valid = 1'b1;
    in_data = 8'h78;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_x_valid", {31'd0, out_valid}, 1);
    chk("post_rst_x_data", {24'd0, out_data}, 32'h78);
    tick();

    // Random traffic against the reference queue model.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0, 1:    b = 8'h20;
        2:       b = ($urandom_range(0, 1) != 0) ? 8'h09 : (($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D);
        3:       b = 8'h00;
        4, 5:    b = 8'h41 + 8'($urandom_range(0, 25));
        6, 7:    b = 8'h61 + 8'($urandom_range(0, 25));
        8:       b = 8'h80 + 8'($urandom_range(0, 127));
        default: b = 8'($urandom_range(0, 255));
      endcase
      in_data = b;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rand_drained", {31'd0, out_valid}, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
